// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped data cache: default sizes,
// address field widths and the controller state encoding.
package data_cache_pkg;

  localparam int DC_WORD_SIZE  = 16;
  localparam int DC_LINE_WORDS = 4;
  localparam int DC_NUM_LINES  = 4;

  // Address split: offset = addr[1:0], index = addr[3:2], tag = upper bits.
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 2;
  localparam int DC_TAG_W = DC_WORD_SIZE - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/data_cache_array.sv
// Tag, valid and data storage for the direct-mapped cache. One combinational
// lookup port, one word write port and a line validate/invalidate port.
module cache_array #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4,
  parameter int TAG_W      = 12,
  parameter int INDEX_W    = 2,
  parameter int OFFSET_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INDEX_W-1:0]   rd_index,
  input  logic [OFFSET_W-1:0]  rd_offset,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [WORD_SIZE-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [OFFSET_W-1:0]  wr_offset,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 line_set,
  input  logic                 line_clr,
  input  logic [INDEX_W-1:0]   line_index,
  input  logic [TAG_W-1:0]     line_tag
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [WORD_SIZE-1:0] data [NUM_LINES][LINE_WORDS];

  // Valid bits are the only reset state; a line being refilled is invalid
  // until its last word lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (line_clr) begin
      valid[line_index] <= 1'b0;
    end else if (line_set) begin
      valid[line_index] <= 1'b1;
    end
  end

  // Tag is written together with the valid bit at the end of a fill.
  always_ff @(posedge clk) begin
    if (line_set) begin
      tags[line_index] <= line_tag;
    end
  end

  // Word writes from fill beats and write-through hits.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data[wr_index][wr_offset] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index][rd_offset];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits complete in the same cycle; misses fill a whole line word by
// word, then the stalled read is retried and hits.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int WORD_SIZE  = DC_WORD_SIZE,
  parameter int LINE_WORDS = DC_LINE_WORDS,
  parameter int NUM_LINES  = DC_NUM_LINES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [WORD_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [WORD_SIZE-1:0] hit_count,
  output logic [WORD_SIZE-1:0] miss_count
);

  localparam int TAG_W = WORD_SIZE - OFFSET_W - INDEX_W;

  state_t                state;
  logic [WORD_SIZE-1:0]  lat_addr;
  logic [WORD_SIZE-1:0]  lat_wdata;
  logic [OFFSET_W-1:0]   word_cnt;
  logic                  retry;

  logic [WORD_SIZE-1:0]  lk_addr;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [WORD_SIZE-1:0]  rd_data;
  logic                  lk_hit;
  logic                  fill_last;
  logic                  req_read;
  logic                  arr_wr_en;
  logic [OFFSET_W-1:0]   arr_wr_offset;
  logic [WORD_SIZE-1:0]  arr_wr_data;
  logic                  arr_line_set;
  logic                  arr_line_clr;

  // In IDLE the lookup follows the live request; otherwise it follows the
  // latched request so the WRITE ack can decide hit/miss on a stable address.
  assign lk_addr   = (state == IDLE) ? cpu_addr : lat_addr;
  assign lk_hit    = rd_valid && (rd_tag == lk_addr[WORD_SIZE-1 -: TAG_W]);
  assign fill_last = (word_cnt == OFFSET_W'(LINE_WORDS - 1));
  // A simultaneous read and write is a write.
  assign req_read  = cpu_read && !cpu_write;

  assign arr_wr_en     = mem_ack && ((state == FILL) || ((state == WRITE) && lk_hit));
  assign arr_wr_offset = (state == FILL) ? word_cnt : lat_addr[OFFSET_W-1:0];
  assign arr_wr_data   = (state == FILL) ? mem_rdata : lat_wdata;
  assign arr_line_set  = (state == FILL) && mem_ack && fill_last;
  assign arr_line_clr  = (state == IDLE) && req_read && !lk_hit;

  cache_array #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .INDEX_W   (INDEX_W),
    .OFFSET_W  (OFFSET_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_index  (lk_addr[OFFSET_W +: INDEX_W]),
    .rd_offset (lk_addr[OFFSET_W-1:0]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (arr_wr_en),
    .wr_index  (lat_addr[OFFSET_W +: INDEX_W]),
    .wr_offset (arr_wr_offset),
    .wr_data   (arr_wr_data),
    .line_set  (arr_line_set),
    .line_clr  (arr_line_clr),
    .line_index(lk_addr[OFFSET_W +: INDEX_W]),
    .line_tag  (lat_addr[WORD_SIZE-1 -: TAG_W])
  );

  // Controller FSM, request latches and statistics. Each access is counted
  // once: a miss on entry to FILL, and the retried read that follows the
  // fill completes that same access, so it is not counted again as a hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      word_cnt   <= '0;
      retry      <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          retry <= 1'b0;
          if (cpu_write) begin
            lat_addr  <= cpu_addr;
            lat_wdata <= cpu_wdata;
            state     <= WRITE;
          end else if (cpu_read) begin
            if (lk_hit) begin
              if (!retry) begin
                hit_count <= hit_count + WORD_SIZE'(1);
              end
            end else begin
              lat_addr   <= cpu_addr;
              word_cnt   <= '0;
              miss_count <= miss_count + WORD_SIZE'(1);
              state      <= FILL;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            word_cnt <= word_cnt + OFFSET_W'(1);
            if (fill_last) begin
              retry <= 1'b1;
              state <= IDLE;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from the registered state; everything is forced to zero
  // while reset is high so a reset mid-transfer drops requests immediately.
  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      cpu_rdata = rd_data;
      case (state)
        IDLE: begin
          cpu_ready = !cpu_write && !(req_read && !lk_hit);
        end
        FILL: begin
          mem_read = 1'b1;
          mem_addr = {lat_addr[WORD_SIZE-1:OFFSET_W], word_cnt};
        end
        WRITE: begin
          mem_write = 1'b1;
          mem_addr  = lat_addr;
          mem_wdata = lat_wdata;
          cpu_ready = mem_ack;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized self-checking bench for data_cache. The reference model works
// at the access level: a table of valid/tag per line, a sparse memory image,
// and the expected hit/miss counts and stall lengths of each access.
module tb_data_cache;

  logic        clk;
  logic        reset;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [15:0] bmem [int];
  bit          mvalid [4];
  logic [11:0] mtag [4];
  int          exp_hits;
  int          exp_misses;

  data_cache dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (bmem.exists(int'(a))) return bmem[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mvalid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_read"},   {31'b0, mem_read},  0);
    check({tag, "_mem_write"},  {31'b0, mem_write}, 0);
    check({tag, "_mem_addr"},   {16'b0, mem_addr},  0);
    check({tag, "_mem_wdata"},  {16'b0, mem_wdata}, 0);
    check({tag, "_cpu_rdata"},  {16'b0, cpu_rdata}, 0);
    check({tag, "_hit_count"},  {16'b0, hit_count}, 0);
    check({tag, "_miss_count"}, {16'b0, miss_count}, 0);
  endtask

  // One CPU access, held until cpu_ready. The memory side acks each request
  // after 'lat' waiting cycles. Called right after a falling edge.
  task automatic access(input bit wr, input bit rd, input logic [15:0] addr,
                        input logic [15:0] wdata, input int lat);
    bit          is_wr;
    bit          hit;
    bit          ready;
    bit          done;
    int          idx;
    int          exp_stall;
    int          stall;
    int          beats;
    int          wcnt;
    int          cyc;
    logic [11:0] tg;
    logic [15:0] rdata;
    is_wr = wr;
    idx   = int'(addr[3:2]);
    tg    = addr[15:4];
    hit   = !is_wr && mvalid[idx] && (mtag[idx] == tg);
    exp_stall = is_wr ? 1 + lat : (hit ? 0 : 1 + 4 * (lat + 1));
    stall = 0; beats = 0; wcnt = 0; cyc = 0; done = 1'b0; rdata = '0;
    cpu_write = wr;
    cpu_read  = rd;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    while (!done) begin
      mem_ack = 1'b0;
      #1;
      check("mem_excl", {31'b0, mem_read & mem_write}, 0);
      if (mem_read || mem_write) begin
        if (wcnt == lat) begin
          mem_ack = 1'b1;
          wcnt = 0;
          if (mem_read) begin
            check("fill_addr", {16'b0, mem_addr}, {16'b0, addr[15:2], 2'b00} + beats);
            mem_rdata = mem_rd(mem_addr);
            beats++;
          end else begin
            check("wr_addr", {16'b0, mem_addr}, {16'b0, addr});
            check("wr_data", {16'b0, mem_wdata}, {16'b0, wdata});
            bmem[int'(addr)] = wdata;
          end
        end else begin
          wcnt++;
          mem_rdata = 16'($urandom);
        end
      end
      #1;
      ready = cpu_ready;
      rdata = cpu_rdata;
      @(posedge clk);
      @(negedge clk);
      if (ready) done = 1'b1;
      else stall++;
      cyc++;
      if (!done && cyc > 100) begin
        check("timeout", 1, 0);
        done = 1'b1;
      end
    end
    mem_ack   = 1'b0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    check(is_wr ? "wr_stall" : "rd_stall", stall, exp_stall);
    if (is_wr) begin
      check("wr_fill_beats", beats, 0);
    end else begin
      check("fill_beats", beats, hit ? 0 : 4);
      check("rdata", {16'b0, rdata}, {16'b0, mem_rd(addr)});
      if (hit) exp_hits++;
      else begin
        exp_misses++;
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
      end
    end
    check("hit_count",  {16'b0, hit_count},  exp_hits);
    check("miss_count", {16'b0, miss_count}, exp_misses);
  endtask

  // Idle cycles with stray mem_ack pulses, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      #1;
      check("idle_ready", {31'b0, cpu_ready}, 1);
      check("idle_mem_req", {30'b0, mem_read, mem_write}, 0);
      @(posedge clk);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check("idle_hit_count",  {16'b0, hit_count},  exp_hits);
    check("idle_miss_count", {16'b0, miss_count}, exp_misses);
  endtask

  initial begin
    logic [15:0] a;
    int          r;
    int          lat;
    reset     = 1'b0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 4; i++) bmem[16 + i] = 16'h00A0 + 16'(i);
    model_reset();

    #2 reset = 1'b1;
    #1 check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // cold miss on 0x0012, then hit on 0x0011
    access(0, 1, 16'h0012, 16'h0, 0);
    check("first_miss_data_A2", {16'b0, mem_rd(16'h0012)}, 32'h00A2);
    check("first_miss_count", {16'b0, miss_count}, 1);
    access(0, 1, 16'h0011, 16'h0, 0);
    check("first_hit_count", {16'b0, hit_count}, 1);

    // write hit with a slow ack, then read back
    access(1, 0, 16'h0013, 16'h5555, 2);
    access(0, 1, 16'h0013, 16'h0, 0);
    check("write_hit_readback_hits", {16'b0, hit_count}, 2);

    // write miss does not allocate
    access(1, 0, 16'h0100, 16'h1234, 0);
    access(0, 1, 16'h0100, 16'h0, 1);
    check("write_miss_no_alloc", {16'b0, miss_count}, 2);

    // same index, different tags evict each other
    access(0, 1, 16'h0040, 16'h0, 0);
    access(0, 1, 16'h0000, 16'h0, 0);
    access(0, 1, 16'h0040, 16'h0, 0);
    check("evict_miss_count", {16'b0, miss_count}, 5);

    // reset after two fill beats
    idle(1);
    cpu_read = 1'b1;
    cpu_addr = 16'h0084;
    @(posedge clk);
    @(negedge clk);
    check("fill_active", {31'b0, mem_read}, 1);
    repeat (2) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_rd(mem_addr);
      @(posedge clk);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("midfill_rst");
    cpu_read = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    access(0, 1, 16'h0084, 16'h0, 0);
    access(0, 1, 16'h0012, 16'h0, 0);

    // randomized mix
    repeat (80) begin
      r   = int'($urandom_range(0, 9));
      a   = 16'(($urandom_range(0, 5) << 4) | $urandom_range(0, 15));
      lat = int'($urandom_range(0, 2));
      if (r < 2)      access(1, 1, a, 16'($urandom), lat);
      else if (r < 4) access(1, 0, a, 16'($urandom), lat);
      else            access(0, 1, a, 16'h0, lat);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
